aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_inv_cipher_iter.sv | 162 ++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher. One 128-bit block is processed in 2*NR cycles.
// Each inverse round spends one cycle on InvShiftRows/InvSubBytes (SUB) and one
// cycle on AddRoundKey/InvMixColumns (ADD). Round keys come from an external
// store, addressed by rk_idx.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] pt_out
);

  typedef enum logic [2:0] {IDLE, SUB, ADD, FSUB, FADD} st_e;

  st_e          state_q;
  logic [3:0]   rnd_q;
  logic [127:0] blk_q, sub_q, pt_q;
  logic         busy_q, done_q;
  logic [127:0] sub_d, mix_d;

  // GF(2^8) multiply by x, reduced mod 0x11B
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254. The addition chain is
  // 2, 3, 12, 15, 240, 252, 254. It maps 0 to 0, as the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(x3, x3);
    x12  = gmul(x12, x12);
    x15  = gmul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(a);
  endfunction

  // InvShiftRows then InvSubBytes. Row r of column c comes from column c-r.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [7:0] imc_coef(input int k);
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // InvMixColumns: out[r] = sum over k of coef[(k-r) mod 4] * in[k]
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], imc_coef((k - r + 4) % 4));
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  // SUB and FSUB share this datapath, and ADD uses the mix datapath.
  assign sub_d = inv_sub_shift(blk_q);
  assign mix_d = inv_mix(sub_q ^ rk_in);

  // Round-key index depends only on state and round, never on rk_in
  always_comb begin
    rk_idx = rnd_q;
    case (state_q)
      IDLE:    rk_idx = 4'(NR);
      FADD:    rk_idx = 4'd0;
      default: rk_idx = rnd_q;
    endcase
  end

  // Control FSM and datapath registers. Reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rnd_q   <= 4'(NR);
      blk_q   <= '0;
      sub_q   <= '0;
      pt_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          blk_q   <= ct_in ^ rk_in;
          rnd_q   <= 4'(NR - 1);
          busy_q  <= 1'b1;
          state_q <= SUB;
        end
        SUB: begin
          sub_q   <= sub_d;
          state_q <= ADD;
        end
        ADD: begin
          blk_q <= mix_d;
          if (rnd_q == 4'd1) state_q <= FSUB;
          else begin
            rnd_q   <= rnd_q - 4'd1;
            state_q <= SUB;
          end
        end
        FSUB: begin
          sub_q   <= sub_d;
          state_q <= FADD;
        end
        FADD: begin
          pt_q    <= sub_q ^ rk_in;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign pt_out = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter. A forward AES model (S-box, key expansion,
// encrypt) is built from first principles. Expected plaintexts go to a
// scoreboard queue when start is driven, and are popped when done fires.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, busy, done;
  logic [127:0] ct_in, rk_in, pt_out;
  logic [3:0]   rk_idx;
  logic         start14, busy14, done14;
  logic [127:0] ct14, rk14_in, pt14;
  logic [3:0]   rk_idx14;

  aes_inv_cipher_iter #(.NR(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ct_in(ct_in), .rk_idx(rk_idx),
    .rk_in(rk_in), .busy(busy), .done(done), .pt_out(pt_out));

  aes_inv_cipher_iter #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .start(start14), .ct_in(ct14), .rk_idx(rk_idx14),
    .rk_in(rk14_in), .busy(busy14), .done(done14), .pt_out(pt14));

  int n_chk = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Forward AES model
  logic [7:0]   sbox [0:255];
  logic [127:0] ks [0:14];
  logic [127:0] bank [0:1][0:14];
  logic [127:0] bank14 [0:14];
  logic         bsel;

  always_comb rk_in   = (rk_idx   <= 4'd14) ? bank[bsel][rk_idx] : '0;
  always_comb rk14_in = (rk_idx14 <= 4'd14) ? bank14[rk_idx14]  : '0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 0; t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[a] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // The key sits left-aligned in a 256-bit field, and nk is 4 or 8 words.
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_bank(input int b);
    for (int r = 0; r < 15; r++) bank[b][r] = ks[r];
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ks[0];
    for (int r = 1; r <= nr; r++) begin
      for (int b = 0; b < 16; b++) s[127-8*b -: 8] = sbox[s[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[127-8*(4*c+q) -: 8] = s[127-8*(4*((c+q)%4)+q) -: 8];
      if (r != nr)
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          t[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      s = t ^ ks[r];
    end
    return s;
  endfunction

  // Scoreboard
  typedef struct {logic [127:0] pt; int cyc;} exp_t;
  exp_t sbq [$];

  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sbq.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("pt_out", pt_out, e.pt);
        chk("latency", 128'(cyc - e.cyc), 20);
      end
    end
  end

  // Called at a negedge. The start edge is the next posedge.
  task automatic go(input logic [127:0] ct, input logic [127:0] exp_pt);
    ct_in = ct;
    start = 1'b1;
    sbq.push_back('{pt: exp_pt, cyc: cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int bad, n, c1, c0;
    logic [127:0] key, pt;
    rst = 1'b0; start = 1'b0; ct_in = '0; start14 = 1'b0; ct14 = '0; bsel = 1'b0;
    build_sbox();
    expand({K1, 128'h0}, 4); load_bank(0); load_bank(1);
    expand(K3, 8);
    for (int r = 0; r < 15; r++) bank14[r] = ks[r];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pt", pt_out, 0);
    chk("rst_rkidx", rk_idx, 10);
    chk("rst_rkidx14", rk_idx14, 14);
    rst = 1'b1;
    @(negedge clk);

    // C.1: busy is held and done is absent for 20 cycles, then done fires
    go(CT1, PT1);
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!busy || done) bad++;
      @(negedge clk);
    end
    chk("c1_busy_hold", bad, 0);
    chk("c1_done_at20", done, 1);
    @(negedge clk);
    chk("c1_done_pulse", done, 0);
    chk("c1_busy_off", busy, 0);

    // App B: rk_idx sequence
    expand({K2, 128'h0}, 4); load_bank(0);
    chk("rk_idle", rk_idx, 10);
    go(CT2, PT2);
    for (int k = 1; k <= 20; k++) begin
      if (k % 2 == 0) chk("rk_seq", rk_idx, (k == 20) ? 0 : 10 - k / 2);
      @(negedge clk);
    end
    wait_done(2);
    @(negedge clk);

    // Back-to-back with start held high. ct_in changes mid-block.
    expand({K1, 128'h0}, 4); load_bank(0);
    expand({K2, 128'h0}, 4); load_bank(1);
    bsel = 1'b0;
    ct_in = CT1;
    start = 1'b1;
    sbq.push_back('{pt: PT1, cyc: cyc + 1});
    @(negedge clk);
    ct_in = CT2;
    wait_done(25);
    c1 = cyc;
    bsel = 1'b1;
    sbq.push_back('{pt: PT2, cyc: cyc + 1});
    @(negedge clk);
    bad = 0; n = 0;
    while (!done && n < 30) begin
      if (pt_out !== PT1) bad++;
      @(negedge clk);
      n++;
    end
    chk("b2b_hold", bad, 0);
    chk("b2b_gap", 128'(cyc - c1), 21);
    start = 1'b0;
    @(negedge clk);
    bsel = 1'b0;

    // Async reset mid-operation
    expand({K1, 128'h0}, 4); load_bank(0);
    go(CT1, PT1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pt", pt_out, 0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    go(CT1, PT1);
    wait_done(25);
    @(negedge clk);

    // Encrypt/decrypt loopback
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand({key, 128'h0}, 4); load_bank(0);
      go(encrypt(pt, 10), pt);
      wait_done(25);
      @(negedge clk);
    end

    // NR=14 build, C.3
    ct14 = CT3;
    start14 = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    start14 = 1'b0;
    n = 0;
    while (!done14 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("c3_done", done14, 1);
    chk("c3_pt", pt14, PT1);
    chk("c3_latency", 128'(cyc - c0), 28);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
